// File: rtl/counter_arb_pkg.sv
// Shared state encodings, beat-counter width and pointer helper for counter_arbiter.
package counter_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int BW = 4;

  // Next round-robin start position after index i, wrapping at n.
  function automatic logic [2:0] wrap_inc(input logic [2:0] i, input int n);
    logic [3:0] s;
    s = {1'b0, i} + 4'd1;
    return (int'(s) >= n) ? 3'd0 : s[2:0];
  endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] pick,
  output logic [2:0]      idx,
  output logic            valid
);

  logic [7:0]      req_pad;
  logic [2:0]      cand [NREQ];
  logic [NREQ-1:0] hit;

  assign req_pad = 8'(req);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum      = {1'b0, ptr} + 4'(gi);
      assign cand[gi] = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
      assign hit[gi]  = req_pad[cand[gi]];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx   = cand[k];
        valid = 1'b1;
      end
    end
    pick = valid ? (NREQ'(1'b1) << idx) : '0;
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting a shared counter's count-enable in bursts of BURST beats.
// Optional COUNTER_ARB_LOCK_EN adds a lock input that extends the owner's burst.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BURST = 3,
  parameter int CW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      owner,
  output logic            cnt_x,
  input  logic [CW-1:0]   cnt_z,
  output logic [CW-1:0]   z_snap,
  output logic            burst_done
`ifdef COUNTER_ARB_LOCK_EN
  ,
  input  logic            lock
`endif
);

  state_t          state_reg, state_next;
  logic [BW-1:0]   beat_reg, beat_next;
  logic [2:0]      ptr_reg, ptr_next;
  logic [2:0]      idx_reg, idx_next;

  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [2:0]      owner_reg, owner_next;
  logic            cnt_x_reg, cnt_x_next;
  logic [CW-1:0]   z_snap_reg, z_snap_next;
  logic            burst_done_reg, burst_done_next;

  logic [NREQ-1:0] pick_w;
  logic [2:0]      pick_idx;
  logic            pick_valid;
  logic [7:0]      req_pad;
  logic            req_own;
  logic            last_beat;
  logic            lock_w;
  logic            holding;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .pick  (pick_w),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign req_pad   = 8'(req);
  assign req_own   = req_pad[idx_reg];
  assign last_beat = (beat_reg == BW'(BURST - 1));

`ifdef COUNTER_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          idx_next   = pick_idx;
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        beat_next  = '0;
        state_next = req_own ? S_RUN : S_RELEASE;
      end
      S_RUN: begin
        // A dropped request aborts the burst even while locked.
        if (!req_own) begin
          state_next = S_RELEASE;
        end else if (last_beat) begin
          if (lock_w) beat_next = '0;
          else        state_next = S_RELEASE;
        end else begin
          beat_next = beat_reg + BW'(1);
        end
      end
      S_RELEASE: begin
        ptr_next   = wrap_inc(idx_reg, NREQ);
        beat_next  = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    holding         = (state_next == S_GRANT) || (state_next == S_RUN);
    gnt_next        = holding ? (NREQ'(1'b1) << idx_next) : '0;
    owner_next      = holding ? idx_next : 3'd0;
    cnt_x_next      = (state_next == S_RUN);
    burst_done_next = (state_next == S_RELEASE);
    z_snap_next     = (state_reg == S_RELEASE) ? cnt_z : z_snap_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      beat_reg       <= '0;
      ptr_reg        <= 3'd0;
      idx_reg        <= 3'd0;
      gnt_reg        <= '0;
      owner_reg      <= 3'd0;
      cnt_x_reg      <= 1'b0;
      z_snap_reg     <= '0;
      burst_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      ptr_reg        <= ptr_next;
      idx_reg        <= idx_next;
      gnt_reg        <= gnt_next;
      owner_reg      <= owner_next;
      cnt_x_reg      <= cnt_x_next;
      z_snap_reg     <= z_snap_next;
      burst_done_reg <= burst_done_next;
    end
  end

  assign gnt        = gnt_reg;
  assign owner      = owner_reg;
  assign cnt_x      = cnt_x_reg;
  assign z_snap     = z_snap_reg;
  assign burst_done = burst_done_reg;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: attached counter, cycle-level reference model, directed scenarios.
module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int BURST = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [2:0] owner;
  logic       cnt_x;
  logic [1:0] cnt_z;
  logic [1:0] z_snap;
  logic       burst_done;
  logic       lock;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  counter_arbiter #(.NREQ(NREQ), .BURST(BURST), .CW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .owner      (owner),
    .cnt_x      (cnt_x),
    .cnt_z      (cnt_z),
    .z_snap     (z_snap),
    .burst_done (burst_done)
`ifdef COUNTER_ARB_LOCK_EN
    ,
    .lock       (lock)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared counter driven by the arbiter's count enable.
  always @(posedge clk) begin
    if (!rst)       cnt_z <= 2'd0;
    else if (cnt_x) cnt_z <= cnt_z + 2'd1;
  end

  // Reference model: who holds the counter, how many beats they have had, and
  // whether this cycle is the hand-back cycle.
  int         m_holder  = -1;
  int         m_beats   = 0;
  bit         m_closing = 1'b0;
  int         m_ptr     = 0;
  int         m_count   = 0;
  bit         m_armed   = 1'b0;
  logic [3:0] e_gnt     = '0;
  logic [2:0] e_owner   = '0;
  logic       e_x       = 1'b0;
  logic       e_done    = 1'b0;
  logic [1:0] e_z       = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_armed = 1'b1; m_holder = -1; m_beats = 0; m_closing = 1'b0;
      m_ptr = 0; m_count = 0;
      e_gnt = '0; e_owner = '0; e_x = 1'b0; e_done = 1'b0; e_z = '0;
    end else if (m_armed) begin
      if (e_x) m_count = (m_count + 1) % 4;
      e_done = 1'b0;
      if (m_closing) begin
        e_z = 2'(m_count);
        m_ptr = (m_holder + 1) % NREQ;
        m_holder = -1; m_closing = 1'b0;
        e_gnt = '0; e_owner = '0; e_x = 1'b0;
      end else if (m_holder < 0) begin
        for (int k = 0; k < NREQ; k++)
          if (m_holder < 0 && req[(m_ptr + k) % NREQ]) m_holder = (m_ptr + k) % NREQ;
        if (m_holder >= 0) begin
          e_gnt = 4'(1 << m_holder); e_owner = 3'(m_holder); m_beats = 0;
        end
        e_x = 1'b0;
      end else begin
        if (!req[m_holder])          m_closing = 1'b1;
        else if (m_beats == BURST) begin
          if (lock) m_beats = 1;
          else      m_closing = 1'b1;
        end else                     m_beats = m_beats + 1;
        if (m_closing) begin
          e_gnt = '0; e_owner = '0; e_x = 1'b0; e_done = 1'b1;
        end else begin
          e_x = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_armed) begin
      n_vec++;
      if (gnt !== e_gnt || owner !== e_owner || cnt_x !== e_x ||
          burst_done !== e_done || z_snap !== e_z) begin
        n_err++;
        $display("FAIL model cyc=%0d got gnt=%b own=%0d x=%b done=%b z=%0d want gnt=%b own=%0d x=%b done=%b z=%0d",
                 cyc, gnt, owner, cnt_x, burst_done, z_snap,
                 e_gnt, e_owner, e_x, e_done, e_z);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d (cyc %0d)", name, act, cyc);
    end
  endtask

  task automatic wait_grant(output logic [3:0] g, output int at);
    int n = 0;
    g = '0; at = -1;
    while (gnt != 4'd0 && n < 40) begin @(negedge clk); n++; end
    while (gnt == 4'd0 && n < 40) begin @(negedge clk); n++; end
    if (gnt == 4'd0) begin
      n_vec++; n_err++;
      $display("FAIL wait_grant: got no grant want a grant within 40 cycles");
    end else begin
      g = gnt; at = cyc;
    end
  endtask

  // Counts cnt_x beats from the current negedge until burst_done is seen.
  task automatic run_to_done(output int nx, output bit ok);
    nx = 0; ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (cnt_x) nx++;
      if (burst_done) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL run_to_done: got no burst_done want one within 40 cycles");
    end
  endtask

  initial begin
    logic [3:0] g;
    int at, prev_at, t0, nx;
    bit ok;
    logic [3:0] order [5];
    int zs [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    zs[0] = 0; zs[1] = 3; zs[2] = 2; zs[3] = 1; zs[4] = 0;

    rst = 1'b0; req = 4'b0000; lock = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_cnt_x", int'(cnt_x), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_z_snap", int'(z_snap), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single requester, full burst from counter 0.
    req = 4'b0001; t0 = cyc;
    wait_grant(g, at);
    check("t2_gnt", int'(g), 1);
    check("t2_latency", at - t0, 1);
    run_to_done(nx, ok);
    check("t2_beats", nx, 3);
    req = 4'b0000;
    @(negedge clk);
    check("t2_z_snap", int'(z_snap), 3);

    // All requesting after reset: strict rotation, 6-cycle spacing, wrapping snapshot.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 4'b1111;
    prev_at = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, at);
      check($sformatf("t3_gnt%0d", i), int'(g), int'(order[i]));
      if (i > 0) begin
        check($sformatf("t3_space%0d", i), at - prev_at, BURST + 3);
        check($sformatf("t3_z%0d", i), int'(z_snap), zs[i]);
      end
      prev_at = at;
    end

    // Finish owner 0, then requester 2 aborts after its first beat.
    req = 4'b0001;
    run_to_done(nx, ok);
    req = 4'b0100;
    wait_grant(g, at);
    check("t4_gnt", int'(g), 4);
    @(negedge clk);
    req = 4'b0000;
    run_to_done(nx, ok);
    check("t4_beats", nx, 1);
    req = 4'b1111;
    @(negedge clk);
    check("t4_z_snap", int'(z_snap), 0);
    wait_grant(g, at);
    check("t4_next_gnt", int'(g), 8);
    req = 4'b1000;
    run_to_done(nx, ok);

    // Move ptr to 2, then reset during the second beat of requester 2.
    req = 4'b0010;
    wait_grant(g, at);
    check("t5_pre_gnt", int'(g), 2);
    run_to_done(nx, ok);
    req = 4'b0100;
    wait_grant(g, at);
    check("t5_gnt", int'(g), 4);
    @(negedge clk);
    @(negedge clk);
    check("t5_beat2", int'(cnt_x), 1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_gnt", int'(gnt), 0);
    check("t5_rst_cnt_x", int'(cnt_x), 0);
    check("t5_rst_owner", int'(owner), 0);
    rst = 1'b1; req = 4'b1010;
    wait_grant(g, at);
    check("t5_first_gnt", int'(g), 2);
    req = 4'b0010;
    run_to_done(nx, ok);
    req = 4'b0000;

`ifdef COUNTER_ARB_LOCK_EN
    // Locked owner keeps counting without a release gap.
    repeat (2) @(negedge clk);
    req = 4'b0001; lock = 1'b1;
    wait_grant(g, at);
    check("t6_gnt", int'(g), 1);
    nx = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cnt_x && !burst_done) nx++;
    end
    check("t6_cont_beats", nx, 8);
    lock = 1'b0;
    run_to_done(nx, ok);
    check("t6_done", int'(ok), 1);
    req = 4'b0000;
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
